// File: rtl/rv32_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv32_fetch : RV32 instruction fetch with 2-entry credit-limited queue,
//              redirect flush/discard and halt-word stop.   Rev 1.0
// ---------------------------------------------------------------------------
module rv32_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] code_bus,
  output logic [31:0] if_pc,
  output logic        halted
);

  localparam logic [0:0]  ST_RUN    = 1'b0;
  localparam logic [0:0]  ST_HALT   = 1'b1;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  logic [0:0]       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      tail_pc_q, tail_pc_d;
  logic [1:0][31:0] word_q, word_d;
  logic [1:0][31:0] pc_q, pc_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [1:0]       inflight_q, inflight_d;
  logic [1:0]       discard_q, discard_d;

  logic        issue;
  logic        enq;
  logic        deq;
  logic [31:0] redirect_aligned;
  logic        unused_redirect_lsbs;

  assign redirect_aligned     = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Credit: buffered plus outstanding words may never exceed the queue depth.
  assign imem_req  = rst_n && (state_q == ST_RUN) && !redirect_valid &&
                     (({1'b0, count_q} + {1'b0, inflight_q}) < 3'd2);
  assign imem_addr = fetch_pc_q;
  assign issue     = imem_req && imem_ready;

  assign if_valid = (count_q != 2'd0);
  assign code_bus = if_valid ? word_q[rd_ptr_q] : NOP_WORD;
  assign if_pc    = if_valid ? pc_q[rd_ptr_q] : 32'h0000_0000;
  assign halted   = (state_q == ST_HALT);

  assign enq = imem_rvalid && (discard_q == 2'd0);
  assign deq = if_valid && id_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    tail_pc_d  = tail_pc_q;
    word_d     = word_q;
    pc_d       = pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;

    if (redirect_valid) begin
      // Everything still outstanding belongs to the old path, except a response
      // landing this very cycle, which the flush swallows directly.
      fetch_pc_d = redirect_aligned;
      tail_pc_d  = redirect_aligned;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      count_d    = 2'd0;
      inflight_d = inflight_q - {1'b0, imem_rvalid};
      discard_d  = inflight_q - {1'b0, imem_rvalid};
      state_d    = ST_RUN;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      inflight_d = inflight_q + {1'b0, issue} - {1'b0, imem_rvalid};
      if (imem_rvalid && (discard_q != 2'd0)) begin
        discard_d = discard_q - 2'd1;
      end
      if (enq) begin
        word_d[wr_ptr_q] = imem_rdata;
        pc_d[wr_ptr_q]   = tail_pc_q;
        wr_ptr_d         = ~wr_ptr_q;
        tail_pc_d        = tail_pc_q + 32'd4;
      end
      if (deq) begin
        rd_ptr_d = ~rd_ptr_q;
        if (word_q[rd_ptr_q] == HALT_WORD) begin
          state_d = ST_HALT;
        end
      end
      count_d = count_q + {1'b0, enq} - {1'b0, deq};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      tail_pc_q  <= RESET_PC;
      word_q     <= '0;
      pc_q       <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      inflight_q <= 2'd0;
      discard_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      tail_pc_q  <= tail_pc_d;
      word_q     <= word_d;
      pc_q       <= pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rv32_fetch : randomized bench for rv32_fetch against a queue-based model
//                 of the fetch rules and an in-order memory.   Rev 1.0
// ---------------------------------------------------------------------------
module tb_rv32_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
  localparam logic [31:0] NO_HALT   = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] code_bus;
  logic [31:0] if_pc;
  logic        halted;

  always #5 clk = ~clk;

  rv32_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .if_valid(if_valid), .code_bus(code_bus),
    .if_pc(if_pc), .halted(halted)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: decoder-side queue and counters, plus the memory's pending list.
  logic [31:0] m_word[$];
  logic [31:0] m_pc[$];
  int          m_infl, m_disc;
  logic [31:0] m_fpc, m_tpc;
  bit          m_halt;
  logic [31:0] p_addr[$];
  int          p_due[$];
  int          cyc = 0;
  logic [31:0] halt_addr = NO_HALT;
  int          k_ready, k_lat, k_idr, k_redir;
  logic [31:0] redir_mask = 32'h0000_FFFF;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] w;
    if (a == halt_addr) return 32'hFFFF_FFFF;
    w = {a[31:2] ^ 30'h2AAA_5555, 2'b11};
    if (w == 32'hFFFF_FFFF) w = NOP_WORD;
    return w;
  endfunction

  task automatic model_reset();
    m_word.delete(); m_pc.delete();
    m_infl = 0; m_disc = 0; m_halt = 0;
    m_fpc = RESET_PC; m_tpc = RESET_PC;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_imem_req"}, imem_req, 1'b0);
    check({pfx, "_if_valid"}, if_valid, 1'b0);
    check({pfx, "_code_bus"}, code_bus, NOP_WORD);
    check({pfx, "_if_pc"},    if_pc,    32'h0);
    check({pfx, "_halted"},   halted,   1'b0);
  endtask

  task automatic step(input bit force_redir, input logic [31:0] force_pc);
    bit rv, rd, exp_req, issue;
    logic [31:0] data, pcv;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      check("if_valid", if_valid, m_word.size() > 0);
      check("code_bus", code_bus, (m_word.size() > 0) ? m_word[0] : NOP_WORD);
      check("if_pc",    if_pc,    (m_pc.size() > 0) ? m_pc[0] : 32'h0);
      check("halted",   halted,   m_halt);
    end else begin
      check_reset_outputs("rst");
    end

    rv   = (p_addr.size() > 0) && (p_due[0] <= cyc);
    data = rv ? word_at(p_addr[0]) : $urandom;
    rd   = rst_n && (force_redir || ($urandom_range(999) < k_redir));
    pcv  = force_redir ? force_pc : ($urandom & redir_mask);
    imem_ready     = ($urandom_range(99) < k_ready);
    id_ready       = ($urandom_range(99) < k_idr);
    imem_rvalid    = rv;
    imem_rdata     = data;
    redirect_valid = rd;
    redirect_pc    = pcv;
    #1;
    exp_req = rst_n && !m_halt && !rd && ((m_word.size() + m_infl) < 2);
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, m_fpc);
    issue = exp_req && imem_ready;

    if (rv) begin
      void'(p_addr.pop_front());
      void'(p_due.pop_front());
    end
    if (issue) begin
      p_addr.push_back(m_fpc);
      p_due.push_back(cyc + $urandom_range(k_lat, 1));
    end
    if (!rst_n) return;

    if (rd) begin
      m_fpc = pcv & 32'hFFFF_FFFC;
      m_tpc = m_fpc;
      m_word.delete(); m_pc.delete();
      m_infl = m_infl - int'(rv);
      m_disc = m_infl;
      m_halt = 0;
    end else begin
      if (m_word.size() > 0 && id_ready) begin
        if (m_word[0] == 32'hFFFF_FFFF) m_halt = 1;
        void'(m_word.pop_front());
        void'(m_pc.pop_front());
      end
      if (rv) begin
        m_infl--;
        if (m_disc > 0) m_disc--;
        else begin
          m_word.push_back(data);
          m_pc.push_back(m_tpc);
          m_tpc = m_tpc + 32'd4;
        end
      end
      if (issue) begin
        m_infl++;
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic release_reset();
    #2;
    imem_ready = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0;
    p_addr.delete(); p_due.delete();
    rst_n = 1'b1;
  endtask

  task automatic knobs(input int ready, input int lat, input int idr, input int redir);
    k_ready = ready; k_lat = lat; k_idr = idr; k_redir = redir;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect_valid = 0; redirect_pc = 0; id_ready = 0;
    model_reset();
    knobs(100, 1, 100, 0);
    repeat (3) step(0, 0);
    release_reset();

    // streaming: one word per cycle from RESET_PC
    repeat (20) step(0, 0);

    // decode stall fills the queue, then drains in order
    knobs(100, 1, 0, 0);
    repeat (5) step(0, 0);
    check("stall_if_valid", if_valid, 1'b1);
    check("stall_no_req",   imem_req, 1'b0);
    knobs(100, 1, 100, 0);
    repeat (10) step(0, 0);

    // redirect with long latency so two words are outstanding
    knobs(100, 3, 100, 0);
    repeat (6) step(0, 0);
    step(1, 32'h0000_0100);
    repeat (14) step(0, 0);

    // halt word at 0x8, then redirect out of halt to 0x40
    knobs(100, 1, 100, 0);
    halt_addr = 32'h0000_0008;
    step(1, 32'h0000_0000);
    repeat (20) step(0, 0);
    check("halt_reached", halted, 1'b1);
    halt_addr = NO_HALT;
    step(1, 32'h0000_0041);
    repeat (15) step(0, 0);
    check("halt_left", halted, 1'b0);

    // wrap past the top of the address space
    step(1, 32'hFFFF_FFFC);
    repeat (12) step(0, 0);

    // random mix with frequent halts and redirects near the halt address
    halt_addr  = 32'h0000_0020;
    redir_mask = 32'h0000_003F;
    knobs(70, 3, 60, 30);
    repeat (3000) step(0, 0);

    // asynchronous reset in the middle of a long-latency stream
    halt_addr  = NO_HALT;
    redir_mask = 32'h0000_FFFF;
    knobs(100, 3, 100, 0);
    step(1, 32'h0000_0200);
    repeat (8) step(0, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    model_reset();
    repeat (3) step(0, 0);
    release_reset();
    repeat (20) step(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
